// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and constants for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    localparam int DMEM_BYTES = 512;
    localparam int DMEM_WORDS = 128;

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bank
// Brief    : Word-organised storage with per-byte write enables and a
//            registered (synchronous) read port. The array is not reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int WORDS = DMEM_WORDS,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             i_re,
    input  logic [3:0]       i_be,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] w_merged;

    // Same-cycle read of a word being written returns the new bytes.
    always_comb begin
        w_merged = r_mem[i_idx];
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                w_merged[8*b +: 8] = i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) begin
            o_rdata <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Load/store responder for the core's data memory; splits
//            misaligned accesses into two word accesses while raising busy.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int WORDS = 2 ** IDX_W;

    state_e            r_state;
    logic              r_rd_valid;
    logic              r_err;
    logic [31:0]       r_hold;
    logic              r_is_st;
    logic [IDX_W-1:0]  r_idx2;
    logic [3:0]        r_be2;
    logic [31:0]       r_wd2;
    logic [1:0]        r_lane;
    logic [2:0]        r_f3;
    logic              r_mis;
    logic [31:0]       r_first;

    logic              w_idle;
    logic [1:0]        w_lane;
    logic [IDX_W-1:0]  w_idx;
    logic              w_ld_ok;
    logic              w_st_ok;
    logic              w_go_ld;
    logic              w_go_st;
    logic              w_bad;
    logic              w_mis;
    logic [3:0]        w_mask;
    logic [7:0]        w_wide_be;
    logic [63:0]       w_wide_wd;
    logic [IDX_W-1:0]  w_bank_idx;
    logic [3:0]        w_bank_be;
    logic [31:0]       w_bank_wd;
    logic              w_bank_re;
    logic [31:0]       w_q;
    logic [63:0]       w_sh;
    logic [31:0]       w_ext;

    assign w_idle = (r_state == IDLE);
    assign busy   = (r_state == SECOND);
    assign w_lane = addr[1:0];
    assign w_idx  = addr[ADDR_W-1:2];

    assign w_ld_ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    assign w_st_ok = funct3 inside {F3_B, F3_H, F3_W};
    assign w_go_ld = w_idle && rd && !wr && w_ld_ok;
    assign w_go_st = w_idle && wr && !rd && w_st_ok;
    assign w_bad   = w_idle && ((rd && wr) || (rd && !wr && !w_ld_ok) || (wr && !rd && !w_st_ok));

    // funct3[1:0] gives the size for both signed and unsigned loads.
    always_comb begin
        case (funct3[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_mis     = ((funct3[1:0] == 2'b01) && (w_lane == 2'b11)) ||
                       ((funct3[1:0] == 2'b10) && (w_lane != 2'b00));
    assign w_wide_be = {4'b0000, w_mask} << w_lane;
    assign w_wide_wd = {32'd0, wr_data} << {w_lane, 3'b000};

    // Upper halves of the wide lanes spill into word N+1.
    always_comb begin
        w_bank_idx = w_idx;
        w_bank_wd  = w_wide_wd[31:0];
        w_bank_be  = 4'b0000;
        w_bank_re  = 1'b0;
        if (reset) begin
            w_bank_be = 4'b0000;
        end else if (r_state == SECOND) begin
            w_bank_idx = r_idx2;
            w_bank_wd  = r_wd2;
            w_bank_be  = r_is_st ? r_be2 : 4'b0000;
            w_bank_re  = !r_is_st;
        end else begin
            w_bank_be  = w_go_st ? w_wide_be[3:0] : 4'b0000;
            w_bank_re  = w_go_ld;
        end
    end

    dmem_bank #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (clk),
        .i_re    (w_bank_re),
        .i_be    (w_bank_be),
        .i_idx   (w_bank_idx),
        .i_wdata (w_bank_wd),
        .o_rdata (w_q)
    );

    assign w_sh = (r_mis ? {w_q, r_first} : {32'd0, w_q}) >> {r_lane, 3'b000};

    always_comb begin
        case (r_f3)
            F3_B:    w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
            F3_H:    w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
            F3_BU:   w_ext = {24'd0, w_sh[7:0]};
            F3_HU:   w_ext = {16'd0, w_sh[15:0]};
            default: w_ext = w_sh[31:0];
        endcase
    end

    // The result is formed from registered bank data and metadata in the
    // pulse cycle, then latched so it holds until the next pulse.
    assign rd_data  = r_rd_valid ? w_ext : r_hold;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_hold     <= '0;
            r_is_st    <= 1'b0;
            r_idx2     <= '0;
            r_be2      <= '0;
            r_wd2      <= '0;
            r_lane     <= '0;
            r_f3       <= '0;
            r_mis      <= 1'b0;
            r_first    <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= w_bad;
            if (r_rd_valid) begin
                r_hold <= w_ext;
            end
            if (r_state == IDLE) begin
                if (w_go_ld || w_go_st) begin
                    r_is_st <= w_go_st;
                    r_idx2  <= w_idx + 1'b1;
                    r_be2   <= w_wide_be[7:4];
                    r_wd2   <= w_wide_wd[63:32];
                    if (w_go_ld) begin
                        r_lane <= w_lane;
                        r_f3   <= funct3;
                        r_mis  <= w_mis;
                    end
                    if (w_mis) begin
                        r_state <= SECOND;
                    end else begin
                        r_rd_valid <= w_go_ld;
                    end
                end
            end else begin
                if (!r_is_st) begin
                    r_first    <= w_q;
                    r_rd_valid <= 1'b1;
                end
                r_state <= IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed vector table plus hand sequences for dmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [2:0]  funct3;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        err;

    int n_vec;
    int n_fail;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    dmem_responder #(
        .DATA_W (32),
        .ADDR_W (9)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .funct3   (funct3),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f,
                                input logic [8:0] a, input logic [31:0] d,
                                input logic ev, input logic ee, input logic [31:0] ed);
        vec_t v;
        v.rd = r; v.wr = w; v.f3 = f; v.addr = a; v.wdata = d;
        v.exp_valid = ev; v.exp_err = ee; v.exp_data = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // One request cycle; returns #1 after the accepting edge.
    task automatic cyc(input logic r, input logic w, input logic [2:0] f,
                       input logic [8:0] a, input logic [31:0] d);
        rd = r; wr = w; funct3 = f; addr = a; wr_data = d;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic load1(input string nm, input logic [2:0] f, input logic [8:0] a,
                         input logic [31:0] exp);
        cyc(1'b1, 1'b0, f, a, 32'd0);
        chk(nm, {2'b00, busy, rd_valid, rd_data}, {2'b00, 1'b0, 1'b1, exp});
    endtask

    task automatic load2(input string nm, input logic [2:0] f, input logic [8:0] a,
                         input logic [31:0] exp);
        cyc(1'b1, 1'b0, f, a, 32'd0);
        chk({nm, "_t1"}, {34'd0, busy, rd_valid}, {34'd0, 1'b1, 1'b0});
        @(posedge clk); #1;
        chk({nm, "_t2"}, {2'b00, busy, rd_valid, rd_data}, {2'b00, 1'b0, 1'b1, exp});
    endtask

    initial begin
        logic [31:0] exp_hold;
        n_vec = 0; n_fail = 0;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; funct3 = '0; wr_data = '0;

        tbl.push_back(mk(0, 1, F3_W,  9'h010, 32'hDEADBEEF, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, F3_W,  9'h010, 32'h0,        1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 0, F3_B,  9'h013, 32'h0,        1, 0, 32'hFFFFFFDE));
        tbl.push_back(mk(1, 0, F3_BU, 9'h013, 32'h0,        1, 0, 32'h000000DE));
        tbl.push_back(mk(1, 0, F3_H,  9'h012, 32'h0,        1, 0, 32'hFFFFDEAD));
        tbl.push_back(mk(1, 0, F3_HU, 9'h010, 32'h0,        1, 0, 32'h0000BEEF));
        tbl.push_back(mk(1, 0, F3_H,  9'h010, 32'h0,        1, 0, 32'hFFFFBEEF));
        tbl.push_back(mk(0, 1, F3_W,  9'h020, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 1, F3_B,  9'h021, 32'hFFFFFF7F, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, F3_W,  9'h020, 32'h0,        1, 0, 32'h00007F00));
        tbl.push_back(mk(0, 1, F3_B,  9'h022, 32'h12345680, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, F3_W,  9'h020, 32'h0,        1, 0, 32'h00807F00));
        tbl.push_back(mk(1, 0, F3_HU, 9'h022, 32'h0,        1, 0, 32'h00000080));
        tbl.push_back(mk(1, 0, F3_H,  9'h020, 32'h0,        1, 0, 32'h00007F00));
        tbl.push_back(mk(1, 0, F3_B,  9'h022, 32'h0,        1, 0, 32'hFFFFFF80));
        tbl.push_back(mk(0, 1, F3_H,  9'h020, 32'hAAAA5566, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, F3_W,  9'h020, 32'h0,        1, 0, 32'h00805566));
        tbl.push_back(mk(1, 1, F3_W,  9'h010, 32'h0,        0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 3'b011, 9'h010, 32'h0,       0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 3'b110, 9'h010, 32'h0,       0, 1, 32'h0));
        tbl.push_back(mk(0, 1, F3_BU, 9'h010, 32'h0,        0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 3'b111, 9'h010, 32'h0,       0, 1, 32'h0));
        tbl.push_back(mk(1, 0, F3_W,  9'h010, 32'h0,        1, 0, 32'hDEADBEEF));

        @(posedge clk); #1;
        chk("reset_outputs", {2'b00, busy, rd_valid, err, rd_data[30:0]}, 36'd0);
        chk("reset_rd_data", {4'd0, rd_data}, 36'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        exp_hold = 32'd0;
        for (int i = 0; i < tbl.size(); i++) begin
            rd = tbl[i].rd; wr = tbl[i].wr; funct3 = tbl[i].f3;
            addr = tbl[i].addr; wr_data = tbl[i].wdata;
            @(posedge clk); #1;
            if (tbl[i].exp_valid) exp_hold = tbl[i].exp_data;
            n_vec++;
            if ({rd_valid, err, busy, rd_data} !== {tbl[i].exp_valid, tbl[i].exp_err, 1'b0, exp_hold}) begin
                n_fail++;
                $display("FAIL vec%0d: got v=%b e=%b b=%b d=%h, want v=%b e=%b b=0 d=%h",
                         i, rd_valid, err, busy, rd_data,
                         tbl[i].exp_valid, tbl[i].exp_err, exp_hold);
            end
        end
        rd = 1'b0; wr = 1'b0;

        // Misaligned store, with a load held on the bus while busy.
        cyc(0, 1, F3_W, 9'h0C4, 32'h0);
        cyc(0, 1, F3_W, 9'h0C8, 32'h0);
        cyc(0, 1, F3_W, 9'h0C6, 32'h11223344);
        chk("msw_busy", {35'd0, busy}, 36'd1);
        cyc(1, 0, F3_W, 9'h010, 32'h0);
        chk("msw_ignored", {34'd0, busy, rd_valid}, 36'd0);
        load1("msw_lo", F3_W, 9'h0C4, 32'h33440000);
        load1("msw_hi", F3_W, 9'h0C8, 32'h00001122);
        load2("mlw_c6", F3_W, 9'h0C6, 32'h11223344);
        load2("mlw_c5", F3_W, 9'h0C5, 32'h22334400);
        load2("mlh_c7", F3_H, 9'h0C7, 32'h00002233);

        // Halfword straddling the top of memory wraps to byte 0.
        cyc(0, 1, F3_W, 9'h1FC, 32'h0);
        cyc(0, 1, F3_W, 9'h000, 32'h0);
        cyc(0, 1, F3_H, 9'h1FF, 32'h1234BEEF);
        chk("wrap_busy", {35'd0, busy}, 36'd1);
        @(posedge clk); #1;
        load1("wrap_b511", F3_BU, 9'h1FF, 32'h000000EF);
        load1("wrap_b0", F3_BU, 9'h000, 32'h000000BE);
        load2("wrap_lhu", F3_HU, 9'h1FF, 32'h0000BEEF);
        load2("wrap_lh", F3_H, 9'h1FF, 32'hFFFFBEEF);

        // Reset during the second half of a misaligned store.
        cyc(0, 1, F3_W, 9'h0C8, 32'h0);
        cyc(0, 1, F3_W, 9'h0C6, 32'hAABBCCDD);
        reset = 1'b1;
        #1;
        chk("rst_mid_st", {2'b00, busy, rd_valid, err, rd_data[30:0]}, 36'd0);
        chk("rst_mid_st_d", {4'd0, rd_data}, 36'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        load1("rst_st_lo", F3_W, 9'h0C4, 32'hCCDD0000);
        load1("rst_st_hi", F3_W, 9'h0C8, 32'h00000000);

        // Reset during the second half of a misaligned load.
        cyc(1, 0, F3_W, 9'h0C6, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ld", {34'd0, busy, rd_valid}, 36'd0);
        load1("after_rst", F3_W, 9'h010, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
